// File: rtl/hex_result_tx.sv
// hex_result_tx: captures the ALU result and streams it to the UART TX as ASCII hex digits followed by CR LF
//
// Ports:
//   clk       system clock, rising edge
//   n_rst     synchronous active-low reset
//   result    32-bit product, valid while alu_done is high
//   alu_done  level from the multiplier; its rising edge starts a line
//   tx_done   one-cycle pulse from the UART TX when a byte has finished
//   tx_data   ASCII byte to send, held from tx_start until the matching tx_done
//   tx_start  one-cycle send request to the UART TX
//   fmt_busy  high while a line is being sent
//   fmt_done  one-cycle pulse once the LF has been sent
//
// Optional feature: define HEX_RESULT_TX_ZERO_SUPPRESS_EN to skip leading zero nibbles.
module hex_result_tx #(
  parameter int DIGITS     = 8,
  parameter bit UPPER_CASE = 1'b1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [31:0] result,
  input  logic        alu_done,
  input  logic        tx_done,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        fmt_busy,
  output logic        fmt_done
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;
  localparam logic [3:0] LAST = 4'(DIGITS + 1);
  state_t      state;
  logic        alu_d;
  logic        trigger;
  logic [31:0] cap;
  logic [3:0]  idx;
  logic [3:0]  start;
  assign trigger = alu_done & ~alu_d;
  // Character at line position i: hex digits MSB first, then CR, then LF.
  function automatic logic [7:0] char_of(input logic [3:0] i, input logic [31:0] v);
    logic [3:0] n;
    n = (int'(i) < DIGITS) ? 4'(v >> (4 * (DIGITS - 1 - int'(i)))) : 4'h0;
    return int'(i) == DIGITS ? 8'h0D :
           int'(i) == DIGITS + 1 ? 8'h0A :
           n < 4'd10 ? 8'h30 + 8'(n) :
           (UPPER_CASE ? 8'h37 : 8'h57) + 8'(n);
  endfunction
`ifdef HEX_RESULT_TX_ZERO_SUPPRESS_EN
  // Most significant non-zero nibble wins; the last nibble is always emitted.
  always_comb begin
    start = 4'(DIGITS - 1);
    for (int p = 0; p < DIGITS; p++)
      if (result[4*p +: 4] != 4'h0) start = 4'(DIGITS - 1 - p);
  end
`else
  assign start = 4'h0;
`endif
  // Outputs are registered on entry to each state so tx_start appears the cycle after the deciding edge.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state    <= IDLE;
      alu_d    <= 1'b0;
      cap      <= '0;
      idx      <= '0;
      tx_data  <= 8'h00;
      tx_start <= 1'b0;
      fmt_busy <= 1'b0;
      fmt_done <= 1'b0;
    end else begin
      alu_d <= alu_done;
      case (state)
        IDLE: if (trigger) begin
          cap      <= result;
          idx      <= start;
          tx_data  <= char_of(start, result);
          tx_start <= 1'b1;
          fmt_busy <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          tx_start <= 1'b0;
          state    <= WAIT;
        end
        WAIT: if (tx_done) begin
          if (idx == LAST) begin
            fmt_busy <= 1'b0;
            fmt_done <= 1'b1;
            state    <= DONE;
          end else begin
            idx      <= idx + 4'd1;
            tx_data  <= char_of(idx + 4'd1, cap);
            tx_start <= 1'b1;
            state    <= SEND;
          end
        end
        DONE: begin
          fmt_done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hex_result_tx.sv
// tb_hex_result_tx: directed bench for hex_result_tx (upper-case and lower-case instances)
module tb_hex_result_tx;
  logic        clk = 1'b0;
  logic        n_rst, alu, tx_done, sel;
  logic [31:0] result;
  logic        alu_a, alu_b, done_a, done_b;
  logic [7:0]  data_a, data_b, s_tx_data;
  logic        start_a, start_b, busy_a, busy_b, fin_a, fin_b;
  logic        s_tx_start, s_fmt_busy, s_fmt_done;
  int compared = 0;
  int mismatched = 0;
  logic [7:0] e_1e0 [10];
  int n_1e0;
  logic [7:0] e_zero [10];
  int n_zero;

  always #5 clk = ~clk;

  assign alu_a  = alu & ~sel;
  assign alu_b  = alu & sel;
  assign done_a = tx_done & ~sel;
  assign done_b = tx_done & sel;
  assign s_tx_data  = sel ? data_b : data_a;
  assign s_tx_start = sel ? start_b : start_a;
  assign s_fmt_busy = sel ? busy_b : busy_a;
  assign s_fmt_done = sel ? fin_b : fin_a;

  hex_result_tx #(.DIGITS(8), .UPPER_CASE(1'b1)) dut (
    .clk(clk), .n_rst(n_rst), .result(result), .alu_done(alu_a), .tx_done(done_a),
    .tx_data(data_a), .tx_start(start_a), .fmt_busy(busy_a), .fmt_done(fin_a));

  hex_result_tx #(.DIGITS(8), .UPPER_CASE(1'b0)) dut_lc (
    .clk(clk), .n_rst(n_rst), .result(result), .alu_done(alu_b), .tx_done(done_b),
    .tx_data(data_b), .tx_start(start_b), .fmt_busy(busy_b), .fmt_done(fin_b));

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  // TX model: answers each byte, checking the byte, its latency and its hold during WAIT.
  task automatic collect(input string tag, input int n, input logic [7:0] e [10],
                         input int glitch, input bit early, input int rst_at);
    for (int b = 0; b < n; b++) begin
      int t;
      t = 0;
      while (s_tx_start !== 1'b1 && t < 100) begin
        @(negedge clk);
        t++;
      end
      compared++;
      if (s_tx_start !== 1'b1 || t != 0) begin
        $display("FAIL %s start[%0d]: waited %0d cycles, required 0", tag, b, t);
        mismatched++;
        if (s_tx_start !== 1'b1) return;
      end
      compared++;
      if (s_tx_data !== e[b] || s_fmt_busy !== 1'b1) begin
        $display("FAIL %s byte[%0d]: data %h busy %b, required %h busy 1", tag, b, s_tx_data, s_fmt_busy, e[b]);
        mismatched++;
      end
      if (early) begin
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        compared++;
        if (s_tx_start !== 1'b0 || s_tx_data !== e[b]) begin
          $display("FAIL %s early[%0d]: start %b data %h, required 0 %h", tag, b, s_tx_start, s_tx_data, e[b]);
          mismatched++;
        end
      end else @(negedge clk);
      if (b == glitch) begin
        result = 32'h12345678;
        alu = 1'b0;
        @(negedge clk);
        alu = 1'b1;
      end
      if (b == rst_at) begin
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        compared++;
        if (s_tx_start !== 1'b0 || s_fmt_busy !== 1'b0 || s_tx_data !== 8'h00 || s_fmt_done !== 1'b0) begin
          $display("FAIL %s reset: start %b busy %b data %h done %b, required 0 0 00 0", tag, s_tx_start, s_fmt_busy, s_tx_data, s_fmt_done);
          mismatched++;
        end
        return;
      end
      repeat (8) @(negedge clk);
      compared++;
      if (s_tx_start !== 1'b0 || s_tx_data !== e[b]) begin
        $display("FAIL %s hold[%0d]: start %b data %h, required 0 %h", tag, b, s_tx_start, s_tx_data, e[b]);
        mismatched++;
      end
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
    end
    compared++;
    if (s_fmt_done !== 1'b1 || s_fmt_busy !== 1'b0 || s_tx_start !== 1'b0) begin
      $display("FAIL %s end: done %b busy %b start %b, required 1 0 0", tag, s_fmt_done, s_fmt_busy, s_tx_start);
      mismatched++;
    end
    @(negedge clk);
    compared++;
    if (s_fmt_done !== 1'b0 || s_fmt_busy !== 1'b0) begin
      $display("FAIL %s after: done %b busy %b, required 0 0", tag, s_fmt_done, s_fmt_busy);
      mismatched++;
    end
  endtask

  task automatic pulse_alu(input logic [31:0] v);
    result = v;
    alu = 1'b1;
    @(negedge clk);
    alu = 1'b0;
  endtask

  task automatic test_reset;
    n_rst = 1'b0; alu = 1'b0; tx_done = 1'b0; sel = 1'b0; result = 32'h0;
    repeat (3) @(negedge clk);
    compared++;
    if ({data_a, start_a, busy_a, fin_a} !== 11'h0 || {data_b, start_b, busy_b, fin_b} !== 11'h0) begin
      $display("FAIL reset: a=%h/%b%b%b b=%h/%b%b%b, required 00/000", data_a, start_a, busy_a, fin_a, data_b, start_b, busy_b, fin_b);
      mismatched++;
    end
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if (start_a !== 1'b0 || busy_a !== 1'b0) begin
      $display("FAIL idle: start %b busy %b, required 0 0", start_a, busy_a);
      mismatched++;
    end
  endtask

  task automatic test_basic;
    sel = 1'b0;
    pulse_alu(32'h000001E0);
    collect("basic", n_1e0, e_1e0, -1, 1'b0, -1);
  endtask

  task automatic test_lower_case;
    logic [7:0] e [10];
    e = '{8'h64, 8'h65, 8'h61, 8'h64, 8'h62, 8'h65, 8'h65, 8'h66, 8'h0D, 8'h0A};
    sel = 1'b1;
    pulse_alu(32'hDEADBEEF);
    collect("lower", 10, e, -1, 1'b0, -1);
    sel = 1'b0;
  endtask

  task automatic test_zero;
    pulse_alu(32'h0);
    collect("zero", n_zero, e_zero, -1, 1'b0, -1);
  endtask

  task automatic test_held_alu;
    logic [7:0] e [10];
    int extra;
    e = '{8'h43, 8'h41, 8'h46, 8'h45, 8'h30, 8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A};
    result = 32'hCAFE0123;
    alu = 1'b1;
    @(negedge clk);
    collect("held", 10, e, 2, 1'b0, -1);
    extra = 0;
    repeat (80) begin
      @(negedge clk);
      if (s_tx_start === 1'b1 || s_fmt_busy === 1'b1) extra++;
    end
    compared++;
    if (extra != 0) begin
      $display("FAIL held_extra: %0d busy cycles after line, required 0", extra);
      mismatched++;
    end
    alu = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_early_done;
    logic [7:0] e [10];
    e = '{8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h0D, 8'h0A};
    pulse_alu(32'h89ABCDEF);
    collect("early", 10, e, -1, 1'b1, -1);
  endtask

  task automatic test_reset_mid_line;
    logic [7:0] e [10];
    int stray;
    e = '{8'h41, 8'h35, 8'h41, 8'h35, 8'h41, 8'h35, 8'h41, 8'h35, 8'h0D, 8'h0A};
    pulse_alu(32'hA5A5A5A5);
    collect("midrst", 10, e, -1, 1'b0, 4);
    stray = 0;
    repeat (20) begin
      @(negedge clk);
      if (s_tx_start === 1'b1 || s_fmt_busy === 1'b1 || s_fmt_done === 1'b1) stray++;
    end
    compared++;
    if (stray != 0) begin
      $display("FAIL midrst_quiet: %0d active cycles after reset, required 0", stray);
      mismatched++;
    end
    pulse_alu(32'h000001E0);
    collect("restart", n_1e0, e_1e0, -1, 1'b0, -1);
  endtask

  task automatic test_high_at_release;
    n_rst = 1'b0;
    result = 32'h000001E0;
    alu = 1'b1;
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    collect("release", n_1e0, e_1e0, -1, 1'b0, -1);
    alu = 1'b0;
    @(negedge clk);
  endtask

  initial begin
`ifdef HEX_RESULT_TX_ZERO_SUPPRESS_EN
    e_1e0  = '{8'h31, 8'h45, 8'h30, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    n_1e0  = 5;
    e_zero = '{8'h30, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    n_zero = 3;
`else
    e_1e0  = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h31, 8'h45, 8'h30, 8'h0D, 8'h0A};
    n_1e0  = 10;
    e_zero = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
    n_zero = 10;
`endif
    test_reset;
    test_basic;
    test_lower_case;
    test_zero;
    test_held_alu;
    test_early_done;
    test_reset_mid_line;
    test_high_at_release;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/hex_result_tx.md
Name: hex_result_tx

Overview:
Downstream stage of the Booth multiplier / ALU in the UART hex calculator. Captures the 32-bit result on the rising edge of alu_done. Converts it to ASCII hex digits, MSB first, followed by CR LF. Streams the characters one at a time to the UART transmitter using a start/done handshake.

Parameters:
DIGITS, 8, number of hex nibbles emitted; result bits [4*DIGITS-1:0] are used; legal range 1..8.
UPPER_CASE, 1, 1 = digits A-F as 0x41-0x46; 0 = a-f as 0x61-0x66.

Ports:
clk  input  1  system clock; all logic is on its rising edge.
n_rst  input  1  synchronous, active-low reset, sampled on rising clk.
result  input  32  product from the multiplier; valid while alu_done is high.
alu_done  input  1  level from the multiplier; high while its result is valid.
tx_done  input  1  one-cycle pulse from the UART TX when a byte has finished.
tx_data  output  8  ASCII byte to transmit; held stable from tx_start until the matching tx_done.
tx_start  output  1  one-cycle request to the UART TX to send tx_data.
fmt_busy  output  1  high from capture until the final byte's tx_done has been consumed.
fmt_done  output  1  one-cycle pulse when a complete line has been sent.

Behaviour:
- Reset (n_rst low at a clk edge): state IDLE; tx_data=8'h00, tx_start=0, fmt_busy=0, fmt_done=0; captured value=0; char index=0; alu_done edge register=0.
- Edge detect: alu_d is a registered copy of alu_done. trigger = alu_done & ~alu_d.
  - alu_done held high produces exactly one trigger.
  - alu_done already high at reset release produces a trigger on the first clock.
- IDLE:
  - on trigger, latch result into an internal shift register and set index=0.
  - go to SEND; fmt_busy=1 from the next cycle.
- SEND (one cycle):
  - tx_start=1; tx_data = current character.
  - index 0..DIGITS-1 → hex of nibble [4*(DIGITS-1-index)+:4].
  - index DIGITS → 8'h0D; index DIGITS+1 → 8'h0A.
  - go to WAIT.
- WAIT:
  - tx_start=0; tx_data held.
  - on tx_done: if index==DIGITS+1, go to DONE; otherwise index+1 and go to SEND.
- DONE (one cycle): fmt_done=1, fmt_busy=0, then go to IDLE.
- Latency:
  - trigger sampled at edge N → first tx_start high during cycle N+1.
  - tx_done sampled at edge K → next tx_start high during cycle K+1.
  - tx_done for the LF sampled at edge K → fmt_done high during cycle K+1.
- Nibble conversion: 0-9 → 0x30-0x39; 10-15 → 0x41/0x61 + (n-10), selected by UPPER_CASE.
- Boundaries:
  - trigger while not IDLE is ignored; no queueing; captured value unchanged.
  - tx_done outside WAIT is ignored. This includes a tx_done in the same cycle as tx_start.
  - tx_done is not sampled in SEND; one tx_done advances exactly one character.
  - reset mid-line aborts at once; all outputs return to reset values; no partial CR LF is emitted.
  - result changing after capture does not affect the line in progress.
  - no timeout: WAIT holds indefinitely until tx_done arrives.

Optional Feature:
- Macro: HEX_RESULT_TX_ZERO_SUPPRESS_EN.
- Defined:
  - on capture, leading zero nibbles are skipped. The start index is the first non-zero nibble.
  - result==0 emits the single digit "0" (the last nibble is always emitted).
  - CR LF and the handshake are unchanged.
- Undefined: all DIGITS nibbles are always emitted; no extra logic.

Test Plan:
- result=32'h000001E0, alu_done rising, TX model answers tx_done 10 cycles after each tx_start → bytes 30 30 30 30 30 31 45 30 0D 0A; fmt_done pulses once; fmt_busy low after it.
- result=32'hDEADBEEF with UPPER_CASE=0 → bytes 64 65 61 64 62 65 65 66 0D 0A; first tx_start is exactly 1 cycle after the capturing edge.
- Macro defined, result=32'h000001E0 → bytes 31 45 30 0D 0A. Macro defined, result=32'h0 → bytes 30 0D 0A.
- alu_done held high for 200 cycles, plus a second rising edge with result=32'h12345678 during byte 3 → exactly one line, carrying the first captured value; the second trigger is ignored.
- tx_done pulsed in the same cycle as tx_start, then again in WAIT → only the WAIT pulse advances; the character sequence is unchanged.
- n_rst low for 1 cycle while waiting on byte 5 → tx_start=0, fmt_busy=0, tx_data=00 next cycle. The next alu_done rising edge restarts the line from the first digit.
